// File: rtl/axil_macc_mul_pipe.sv
// Pipelined multiply / multiply-accumulate unit: product registered in the first stage,
// optional delay stages, accumulate/select and sticky overflow in the final stage.
module axil_macc_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 32,
    parameter int dout_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_vld,
    input  logic                  is_signed,
    input  logic                  op,
    input  logic                  acc_clr,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_vld,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);

    localparam int PW  = din0_WIDTH + din1_WIDTH;
    localparam int DLY = NUM_STAGE - 1;
    localparam int TW  = dout_WIDTH + 3;

    // Signed overflow: like-signed addends producing an opposite-signed sum.
    // Unsigned overflow: carry out of the top result bit.
    function automatic logic f_macc_ovf(
        input logic sgn,
        input logic base_msb,
        input logic prod_msb,
        input logic sum_msb,
        input logic carry
    );
        if (sgn)
            return (base_msb == prod_msb) && (sum_msb != base_msb);
        else
            return carry;
    endfunction

    logic [PW-1:0]         w_a_ext;
    logic [PW-1:0]         w_b_ext;
    logic [dout_WIDTH-1:0] w_prod;
    logic [TW-1:0]         w_tok;

    // Low PW bits of the product are independent of signedness once operands are extended.
    always_comb begin
        w_a_ext = {{din1_WIDTH{is_signed & din0[din0_WIDTH-1]}}, din0};
        w_b_ext = {{din0_WIDTH{is_signed & din1[din1_WIDTH-1]}}, din1};
        w_prod  = dout_WIDTH'(w_a_ext * w_b_ext);
        w_tok   = {is_signed, op, acc_clr, w_prod};
    end

    logic                  w_f_vld;
    logic [TW-1:0]         w_f_tok;
    logic                  w_f_sgn;
    logic                  w_f_op;
    logic                  w_f_clr;
    logic [dout_WIDTH-1:0] w_f_prod;

    generate
        if (DLY == 0) begin : g_comb
            assign w_f_vld = in_vld;
            assign w_f_tok = w_tok;
        end else begin : g_pipe
            logic          r_vld_p [DLY];
            logic [TW-1:0] r_tok_p [DLY];

            // Stage p0 registers the product; later entries are pure delay.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DLY; i++) r_vld_p[i] <= 1'b0;
                end else if (ce) begin
                    r_vld_p[0] <= in_vld;
                    for (int i = 1; i < DLY; i++) r_vld_p[i] <= r_vld_p[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (ce) begin
                    r_tok_p[0] <= w_tok;
                    for (int i = 1; i < DLY; i++) r_tok_p[i] <= r_tok_p[i-1];
                end
            end

            assign w_f_vld = r_vld_p[DLY-1];
            assign w_f_tok = r_tok_p[DLY-1];
        end
    endgenerate

    assign {w_f_sgn, w_f_op, w_f_clr, w_f_prod} = w_f_tok;

    logic [dout_WIDTH-1:0] r_acc;
    logic [dout_WIDTH-1:0] w_base;
    logic [dout_WIDTH:0]   w_sum;
    logic                  w_ovf_now;

    always_comb begin
        w_base    = w_f_clr ? '0 : r_acc;
        w_sum     = {1'b0, w_base} + {1'b0, w_f_prod};
        w_ovf_now = f_macc_ovf(w_f_sgn, w_base[dout_WIDTH-1], w_f_prod[dout_WIDTH-1],
                               w_sum[dout_WIDTH-1], w_sum[dout_WIDTH]);
    end

    // Final stage: accumulate/select; bubbles and stalls leave dout, acc and ovf untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_vld <= 1'b0;
            dout    <= '0;
            ovf     <= 1'b0;
            r_acc   <= '0;
        end else if (ce) begin
            out_vld <= w_f_vld;
            if (w_f_vld) begin
                if (w_f_op) begin
                    r_acc <= w_sum[dout_WIDTH-1:0];
                    dout  <= w_sum[dout_WIDTH-1:0];
                    ovf   <= (ovf & ~w_f_clr) | w_ovf_now;
                end else begin
                    r_acc <= w_base;
                    dout  <= w_f_prod;
                    if (w_f_clr) ovf <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_macc_mul_pipe.sv
// Directed bench for axil_macc_mul_pipe: a 32-bit result instance and a 64-bit result
// instance share the same stimulus.
module tb_axil_macc_mul_pipe;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        in_vld;
    logic        is_signed;
    logic        op;
    logic        acc_clr;
    logic [31:0] din0;
    logic [31:0] din1;
    logic        out_vld;
    logic [31:0] dout;
    logic        ovf;
    logic        out_vld64;
    logic [63:0] dout64;
    logic        ovf64;

    int total = 0;
    int bad   = 0;

    axil_macc_mul_pipe #(.ID(1), .NUM_STAGE(3), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .is_signed(is_signed), .op(op),
        .acc_clr(acc_clr), .din0(din0), .din1(din1), .out_vld(out_vld), .dout(dout), .ovf(ovf)
    );

    axil_macc_mul_pipe #(.ID(2), .NUM_STAGE(3), .din0_WIDTH(32), .din1_WIDTH(32), .dout_WIDTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .ce(ce), .in_vld(in_vld), .is_signed(is_signed), .op(op),
        .acc_clr(acc_clr), .din0(din0), .din1(din1), .out_vld(out_vld64), .dout(dout64), .ovf(ovf64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic o, input logic c,
                         input logic [31:0] a, input logic [31:0] b);
        in_vld = v; is_signed = s; op = o; acc_clr = c; din0 = a; din1 = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ce    = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h5, 32'h7);
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (out_vld !== 1'b0 || dout !== 32'h0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold[%0d]: vld=%b dout=%h ovf=%b expected 0 0 0", i, out_vld, dout, ovf);
            end
        end
        reset = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_vld !== 1'b0 || dout !== 32'h0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL reset_after[%0d]: vld=%b dout=%h ovf=%b expected 0 0 0", i, out_vld, dout, ovf);
            end
        end
    endtask

    task automatic test_signed_mul();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7);
        step();
        idle();
        step();
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL smul_early: vld=%b expected 0", out_vld);
        end
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL smul_out: vld=%b dout=%h expected 1 ffffffeb", out_vld, dout);
        end
        step();
        total++;
        if (out_vld !== 1'b0 || dout !== 32'hFFFFFFEB) begin
            bad++;
            $display("FAIL smul_pulse: vld=%b dout=%h expected 0 ffffffeb", out_vld, dout);
        end
    endtask

    task automatic test_sign_select();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
        step();
        idle();
        step();
        total++;
        if (out_vld64 !== 1'b1 || dout64 !== 64'h00000001FFFFFFFE) begin
            bad++;
            $display("FAIL sel_unsigned: vld=%b dout=%h expected 1 00000001fffffffe", out_vld64, dout64);
        end
        step();
        total++;
        if (out_vld64 !== 1'b1 || dout64 !== 64'hFFFFFFFFFFFFFFFE) begin
            bad++;
            $display("FAIL sel_signed: vld=%b dout=%h expected 1 fffffffffffffffe", out_vld64, dout64);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [5];
        exp_d[0] = 32'd6; exp_d[1] = 32'd26; exp_d[2] = 32'd27; exp_d[3] = 32'd81; exp_d[4] = 32'd28;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'd2, 32'd3);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd4, 32'd5);
        step();
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
                1: drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd9, 32'd9);
                2: drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
                default: idle();
            endcase
            step();
            total++;
            if (out_vld !== 1'b1 || dout !== exp_d[i] || ovf !== 1'b0) begin
                bad++;
                $display("FAIL b2b[%0d]: vld=%b dout=%0d ovf=%b expected 1 %0d 0", i, out_vld, dout, ovf, exp_d[i]);
            end
        end
        step();
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: vld=%b expected 0", out_vld);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd3, 32'd3);
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (out_vld !== 1'b0 || dout !== 32'd28) begin
                bad++;
                $display("FAIL stall_pre[%0d]: vld=%b dout=%0d expected 0 28", i, out_vld, dout);
            end
        end
        ce = 1'b1;
        step();
        total++;
        if (out_vld !== 1'b0) begin
            bad++;
            $display("FAIL stall_early: vld=%b expected 0", out_vld);
        end
        idle();
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'd4) begin
            bad++;
            $display("FAIL stall_first: vld=%b dout=%0d expected 1 4", out_vld, dout);
        end
        ce = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if (out_vld !== 1'b1 || dout !== 32'd4) begin
                bad++;
                $display("FAIL stall_hold[%0d]: vld=%b dout=%0d expected 1 4", i, out_vld, dout);
            end
        end
        ce = 1'b1;
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'd9) begin
            bad++;
            $display("FAIL stall_second: vld=%b dout=%0d expected 1 9", out_vld, dout);
        end
        step();
        total++;
        if (out_vld !== 1'b0 || dout !== 32'd9) begin
            bad++;
            $display("FAIL stall_end: vld=%b dout=%0d expected 0 9", out_vld, dout);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h7FFFFFFF, 32'd1);
        step();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'd1, 32'd1);
        step();
        idle();
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'h7FFFFFFF || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_s_first: vld=%b dout=%h ovf=%b expected 1 7fffffff 0", out_vld, dout, ovf);
        end
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'h80000000 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_s_set: vld=%b dout=%h ovf=%b expected 1 80000000 1", out_vld, dout, ovf);
        end
        step();
        total++;
        if (out_vld !== 1'b0 || dout !== 32'h80000000 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_bubble: vld=%b dout=%h ovf=%b expected 0 80000000 1", out_vld, dout, ovf);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'd5, 32'd1);
        step();
        idle();
        step();
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'd5 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear: vld=%b dout=%h ovf=%b expected 1 5 0", out_vld, dout, ovf);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'd1);
        step();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1);
        step();
        idle();
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'hFFFFFFFF || ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_u_first: vld=%b dout=%h ovf=%b expected 1 ffffffff 0", out_vld, dout, ovf);
        end
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'h0 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_u_carry: vld=%b dout=%h ovf=%b expected 1 0 1", out_vld, dout, ovf);
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd7, 32'd7);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd8, 32'd8);
        step();
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd9, 32'd9);
        step();
        reset = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            step();
            total++;
            if (out_vld !== 1'b0 || dout !== 32'h0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid[%0d]: vld=%b dout=%h ovf=%b expected 0 0 0", i, out_vld, dout, ovf);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'd2, 32'd3);
        step();
        idle();
        step();
        step();
        total++;
        if (out_vld !== 1'b1 || dout !== 32'd6 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL rst_first_acc: vld=%b dout=%0d ovf=%b expected 1 6 0", out_vld, dout, ovf);
        end
    endtask

    initial begin
        reset = 1'b1;
        ce    = 1'b1;
        idle();
        test_reset();
        test_signed_mul();
        test_sign_select();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
